load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one-outstanding-op bridge between the core, a req/gnt/rvalid
// memory port and the register-file write port.
module load_store_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_load,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [4:0]  op_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  wb_A3,
  output logic [31:0] wb_WD3,
  output logic [2:0]  wb_WE3,
  output logic        err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, WB} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             ld_q, bad_q;
  logic [2:0]       f3_q;
  logic [1:0]       ofs_q;
  logic [4:0]       rd_q;

  logic             accept, rcap, mem_req_nx, err_nx;
  logic [2:0]       wb_we_nx, mode;
  logic             bad_in;
  logic [3:0]       be_in;
  logic [31:0]      wd_in;

  // Illegal width codes and misaligned halfword/word accesses
  always_comb begin
    unique case (op_funct3)
      3'b000, 3'b100: bad_in = 1'b0;
      3'b001, 3'b101: bad_in = op_addr[0];
      3'b010:         bad_in = |op_addr[1:0];
      default:        bad_in = 1'b1;
    endcase
  end

  // Store byte lanes and replicated data; loads always read the whole word
  always_comb begin
    be_in = 4'b1111;
    wd_in = op_wdata;
    if (!op_load) begin
      unique case (op_funct3[1:0])
        2'b00: begin
          be_in = 4'b0001 << op_addr[1:0];
          wd_in = {4{op_wdata[7:0]}};
        end
        2'b01: begin
          be_in = 4'b0011 << op_addr[1:0];
          wd_in = {2{op_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Register-file write mode for the captured load width
  always_comb begin
    unique case (f3_q)
      3'b000:  mode = 3'b010;
      3'b001:  mode = 3'b011;
      3'b010:  mode = 3'b001;
      3'b100:  mode = 3'b100;
      3'b101:  mode = 3'b101;
      default: mode = 3'b000;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx   = state;
    mem_req_nx = 1'b0;
    err_nx     = 1'b0;
    wb_we_nx   = 3'b000;
    cnt_nx     = '0;
    accept     = 1'b0;
    rcap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (op_valid) begin
          accept     = 1'b1;
          state_nx   = REQ;
          mem_req_nx = !bad_in;
          err_nx     = bad_in;
        end
      end
      REQ: begin
        if (bad_q) begin
          state_nx = IDLE;
        end else if (mem_gnt) begin
          state_nx = ld_q ? WAIT_R : IDLE;
        end else begin
          mem_req_nx = 1'b1;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          rcap     = 1'b1;
          state_nx = WB;
          wb_we_nx = (rd_q == 5'd0) ? 3'b000 : mode;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      WB: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, captured operation and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt_q     <= '0;
      ld_q      <= 1'b0;
      bad_q     <= 1'b0;
      f3_q      <= 3'b000;
      ofs_q     <= 2'b00;
      rd_q      <= 5'd0;
      op_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      wb_A3     <= 5'd0;
      wb_WD3    <= 32'd0;
      wb_WE3    <= 3'b000;
      err       <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt_q    <= cnt_nx;
      op_ready <= (state_nx == IDLE);
      mem_req  <= mem_req_nx;
      wb_WE3   <= wb_we_nx;
      err      <= err_nx;
      if (accept) begin
        ld_q      <= op_load;
        bad_q     <= bad_in;
        f3_q      <= op_funct3;
        ofs_q     <= op_addr[1:0];
        rd_q      <= op_rd;
        mem_we    <= !op_load;
        mem_be    <= be_in;
        mem_addr  <= {op_addr[31:2], 2'b00};
        mem_wdata <= wd_in;
      end
      if (rcap) begin
        wb_A3  <= rd_q;
        wb_WD3 <= mem_rdata >> {ofs_q, 3'b000};
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random loads/stores checked
// against a byte-level reference model; a second instance covers the timeout.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        op_valid, op_valid_t, op_load;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic [4:0]  op_rd;
  logic        mem_gnt, mem_rvalid, mem_gnt_t, mem_rvalid_t;
  logic [31:0] mem_rdata;

  logic        op_ready, mem_req, mem_we, err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, wb_WD3;
  logic [4:0]  wb_A3;
  logic [2:0]  wb_WE3;

  logic        t_op_ready, t_mem_req, t_mem_we, t_err;
  logic [3:0]  t_mem_be;
  logic [31:0] t_mem_addr, t_mem_wdata, t_wb_WD3;
  logic [4:0]  t_wb_A3;
  logic [2:0]  t_wb_WE3;

  int total = 0;
  int bad   = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_load(op_load), .op_funct3(op_funct3), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rd(op_rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_A3(wb_A3), .wb_WD3(wb_WD3), .wb_WE3(wb_WE3), .err(err)
  );

  load_store_unit #(.MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .op_valid(op_valid_t), .op_ready(t_op_ready),
    .op_load(op_load), .op_funct3(op_funct3), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rd(op_rd), .mem_req(t_mem_req), .mem_we(t_mem_we),
    .mem_be(t_mem_be), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_gnt(mem_gnt_t), .mem_rvalid(mem_rvalid_t), .mem_rdata(mem_rdata),
    .wb_A3(t_wb_A3), .wb_WD3(t_wb_WD3), .wb_WE3(t_wb_WE3), .err(t_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on the main instance; memory responds after gd grant-stall
  // cycles and rvd read-latency cycles. Expectations come from access size rules.
  task automatic run_op(input string tag, input logic ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int gd, input int rvd, input logic [31:0] rdata);
    int sz, ofs, reqc, waitc, errs, wbs, ready_c, wb_c, exp_ready;
    logic ebad, granted, rv_sent, exp_wb;
    logic [3:0]  ebe;
    logic [31:0] ewd, ewb;
    logic [2:0]  emode;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    case (f3)
      3'b000:  emode = 3'b010;
      3'b001:  emode = 3'b011;
      3'b010:  emode = 3'b001;
      3'b100:  emode = 3'b100;
      default: emode = 3'b101;
    endcase
    ofs  = int'(a % 4);
    ebad = (sz == 0) ? 1'b1 : ((ofs % sz) != 0);
    ebe  = 4'hF;
    ewd  = wd;
    if (!ld && !ebad) begin
      ebe = 4'h0;
      for (int i = 0; i < sz; i++) ebe[ofs + i] = 1'b1;
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    ewb = rdata >> (8 * ofs);
    exp_wb = ld && !ebad && (rd != 5'd0);
    exp_ready = ebad ? 2 : (ld ? 4 + gd + rvd : 2 + gd);

    @(negedge clk);
    chk({tag, " idle_ready"}, 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_load = ld; op_funct3 = f3; op_addr = a; op_wdata = wd; op_rd = rd;
    reqc = 0; waitc = 0; errs = 0; wbs = 0; ready_c = 0; wb_c = 0;
    granted = 1'b0; rv_sent = 1'b0;
    for (int c = 1; c <= 600 && ready_c == 0; c++) begin
      @(negedge clk);
      op_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (op_ready) ready_c = c;
      if (err) errs++;
      if (wb_WE3 != 3'b000) begin
        wbs++; wb_c = c;
        chk({tag, " wb_A3"}, 32'(wb_A3), 32'(rd));
        chk({tag, " wb_WD3"}, wb_WD3, ewb);
        chk({tag, " wb_WE3"}, 32'(wb_WE3), 32'(emode));
      end
      if (mem_req) begin
        reqc++;
        chk({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, " mem_we"}, 32'(mem_we), 32'(!ld));
        chk({tag, " mem_be"}, 32'(mem_be), 32'(ebe));
        if (!ld) chk({tag, " mem_wdata"}, mem_wdata, ewd);
        if (reqc > gd) begin
          mem_gnt = 1'b1; granted = 1'b1;
        end else begin
          mem_rvalid = 1'($urandom_range(0, 1));
        end
      end else if (granted && ld && !rv_sent) begin
        waitc++;
        if (waitc > rvd) begin
          mem_rvalid = 1'b1; mem_rdata = rdata; rv_sent = 1'b1;
        end
      end
    end
    chk({tag, " ready_cycle"}, 32'(ready_c), 32'(exp_ready));
    chk({tag, " err_pulses"}, 32'(errs), 32'(ebad));
    chk({tag, " req_cycles"}, 32'(reqc), ebad ? 32'd0 : 32'(gd + 1));
    chk({tag, " wb_pulses"}, 32'(wbs), 32'(exp_wb));
    if (exp_wb) chk({tag, " wb_cycle"}, 32'(wb_c), 32'(3 + gd + rvd));
  endtask

  initial begin
    logic [2:0] f3;
    rst = 1'b0; op_valid = 1'b0; op_valid_t = 1'b0; op_load = 1'b0; op_funct3 = 3'b000;
    op_addr = 32'd0; op_wdata = 32'd0; op_rd = 5'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_gnt_t = 1'b0; mem_rvalid_t = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst op_ready", 32'(op_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst wb_WE3", 32'(wb_WE3), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst t_op_ready", 32'(t_op_ready), 32'd1);
    rst = 1'b1;

    run_op("lb_103", 1'b1, 3'b000, 32'h103, 32'h0, 5'd9, 0, 0, 32'h80FF_1234);
    run_op("sh_202", 1'b0, 3'b001, 32'h202, 32'h0000_ABCD, 5'd3, 0, 0, 32'h0);
    run_op("lw_105", 1'b1, 3'b010, 32'h105, 32'h0, 5'd4, 0, 0, 32'h0);
    run_op("lhu_002", 1'b1, 3'b101, 32'h002, 32'h0, 5'd17, 3, 5, 32'hFEDC_0000);
    run_op("sw_imm", 1'b0, 3'b010, 32'h1000, 32'hDEAD_BEEF, 5'd1, 0, 0, 32'h0);
    run_op("bad_f3", 1'b0, 3'b011, 32'h0, 32'h1, 5'd1, 0, 0, 32'h0);
    run_op("lb_rd0", 1'b1, 3'b100, 32'h41, 32'h0, 5'd0, 1, 1, 32'h1234_5678);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
        3: f3 = 3'b100; 4: f3 = 3'b101;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      run_op("rand", 1'($urandom_range(0, 1)), f3, $urandom, $urandom,
             5'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)), $urandom);
    end

    // Timeout instance: rvalid withheld, late rvalid must be ignored
    @(negedge clk);
    op_valid_t = 1'b1; op_load = 1'b1; op_funct3 = 3'b010; op_addr = 32'h40; op_rd = 5'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      op_valid_t = 1'b0; mem_gnt_t = 1'b0; mem_rvalid_t = 1'b0;
      chk("to wb_WE3", 32'(t_wb_WE3), 32'd0);
      if (c == 1) begin
        chk("to mem_req", 32'(t_mem_req), 32'd1);
        mem_gnt_t = 1'b1;
      end else if (c <= 5) begin
        chk("to err_early", 32'(t_err), 32'd0);
        chk("to busy", 32'(t_op_ready), 32'd0);
        chk("to no_req", 32'(t_mem_req), 32'd0);
      end else if (c == 6) begin
        chk("to err_pulse", 32'(t_err), 32'd1);
        chk("to ready", 32'(t_op_ready), 32'd1);
      end else if (c == 7) begin
        chk("to err_end", 32'(t_err), 32'd0);
        mem_rvalid_t = 1'b1;
      end
    end

    // Reset while waiting for read data
    @(negedge clk);
    op_valid = 1'b1; op_load = 1'b1; op_funct3 = 3'b010; op_addr = 32'h10; op_rd = 5'd7;
    @(negedge clk);
    op_valid = 1'b0;
    chk("rstw mem_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rstw op_ready", 32'(op_ready), 32'd1);
    chk("rstw mem_req", 32'(mem_req), 32'd0);
    chk("rstw mem_addr", mem_addr, 32'd0);
    chk("rstw wb_WE3", 32'(wb_WE3), 32'd0);
    chk("rstw err", 32'(err), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("rstw no_wb", 32'(wb_WE3), 32'd0);
      chk("rstw no_err", 32'(err), 32'd0);
    end
    run_op("lw_rd0", 1'b1, 3'b010, 32'h20, 32'h0, 5'd0, 0, 0, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
